// File: rtl/count_to_bits_expander_pkg.sv
// Shared constants, FSM encoding and thermometer helper for the count-to-bits expander.
// Latency: not applicable (declarations only).
// Backpressure: not applicable (declarations only).
package count_to_bits_expander_pkg;

  localparam int LANES  = 15;
  localparam int CNT_W  = 8;
  localparam int ONES_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // LSB-packed ones mask; counts above LANES saturate to all ones.
  function automatic logic [LANES-1:0] therm(input logic [ONES_W-1:0] n);
    logic [LANES-1:0] m;
    m = '0;
    for (int i = 0; i < LANES; i++) begin
      m[i] = (32'(n) > i);
    end
    return m;
  endfunction

endpackage

// File: rtl/count_to_bits_expander_therm.sv
// Thermometer decoder: ones count n becomes a mask with its ones packed at the LSBs.
// Latency: purely combinational.
// Backpressure: none; output follows n directly, n > LANES saturates to all ones.
module count_to_bits_expander_therm #(
  parameter int LANES  = count_to_bits_expander_pkg::LANES,
  parameter int ONES_W = count_to_bits_expander_pkg::ONES_W
) (
  input  logic [ONES_W-1:0] n,
  output logic [LANES-1:0]  mask
);

  // Bit i is set whenever more than i ones are requested.
  always_comb begin
    mask = '0;
    for (int i = 0; i < LANES; i++) begin
      mask[i] = (32'(n) > i);
    end
  end

endmodule

// File: rtl/count_to_bits_expander.sv
// Expands a ones-count into LSB-packed thermometer beats whose popcounts sum to the count.
// Latency: first beat registered one cycle after the input transfer; later beats follow with no bubbles.
// Backpressure: beat and remaining count hold while out_valid & ~out_ready; a new count is taken only as the last beat leaves.
module count_to_bits_expander
  import count_to_bits_expander_pkg::*;
#(
  parameter int LANES  = count_to_bits_expander_pkg::LANES,
  parameter int CNT_W  = count_to_bits_expander_pkg::CNT_W,
  parameter int ONES_W = count_to_bits_expander_pkg::ONES_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  in_count,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LANES-1:0]  out_bits,
  output logic [ONES_W-1:0] out_ones,
  output logic              out_last
);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    remaining_q;
  logic [LANES-1:0]    bits_q;
  logic [ONES_W-1:0]   ones_q;
  logic                last_q;

  logic                in_xfer, out_xfer;
  logic                load_beat, go_idle;
  logic [CNT_W-1:0]    rem_src, rem_next;
  logic [ONES_W-1:0]   n_sel;
  logic [LANES-1:0]    mask;

  assign out_valid = (state_q == EMIT);
  assign out_bits  = bits_q;
  assign out_ones  = ones_q;
  assign out_last  = last_q;

  // Ready when nothing is held, or the held last beat is leaving this cycle.
  assign in_ready = ~out_valid | (out_ready & last_q);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // A fresh count always takes priority as the source; otherwise continue the burst.
  always_comb begin
    rem_src = in_xfer ? in_count : remaining_q;
    n_sel   = (rem_src >= CNT_W'(LANES)) ? ONES_W'(LANES) : rem_src[ONES_W-1:0];
    rem_next = rem_src - CNT_W'(n_sel);
  end

  count_to_bits_expander_therm #(
    .LANES  (LANES),
    .ONES_W (ONES_W)
  ) u_therm (
    .n    (n_sel),
    .mask (mask)
  );

  // Next-state: load a beat on accept or mid-burst advance, drop to IDLE after an unreplaced last beat.
  always_comb begin
    state_d   = state_q;
    load_beat = 1'b0;
    go_idle   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_xfer) begin
          state_d   = EMIT;
          load_beat = 1'b1;
        end
      end
      EMIT: begin
        if (out_xfer) begin
          if (!last_q || in_xfer) begin
            load_beat = 1'b1;
          end else begin
            state_d = IDLE;
            go_idle = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        go_idle = 1'b1;
      end
    endcase
  end

  // State, remaining counter and output register; cleared on reset and when the block idles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      bits_q      <= '0;
      ones_q      <= '0;
      last_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_beat) begin
        bits_q      <= mask;
        ones_q      <= n_sel;
        last_q      <= (rem_next == '0);
        remaining_q <= rem_next;
      end else if (go_idle) begin
        bits_q      <= '0;
        ones_q      <= '0;
        last_q      <= 1'b0;
        remaining_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_count_to_bits_expander.sv
// Directed bench for the count-to-bits expander with per-scenario inline checks.
// Latency: checks the one-cycle accept-to-first-beat latency and zero-bubble advances.
// Backpressure: random out_ready stalls with output-stability checks.
module tb_count_to_bits_expander;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_count;
  logic        out_valid;
  logic        out_ready;
  logic [14:0] out_bits;
  logic [3:0]  out_ones;
  logic        out_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [14:0] q_bits[$];
  logic [3:0]  q_ones[$];
  logic        q_last[$];
  logic        q_rdy[$];

  count_to_bits_expander dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bits  (out_bits),
    .out_ones  (out_ones),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a count and hold it until accepted; returns at posedge+1 after the transfer.
  task automatic accept(input logic [7:0] cnt, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    in_count = cnt;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_count = 8'hA5;
  endtask

  // Consume beats until the last one, with out_ready high ready_pct percent of cycles.
  task automatic collect(input int ready_pct, output bit ok, output int stable_err);
    logic        held;
    logic [14:0] hb;
    logic [3:0]  ho;
    logic        hl;
    q_bits.delete(); q_ones.delete(); q_last.delete(); q_rdy.delete();
    ok = 1'b0; stable_err = 0; held = 1'b0; hb = '0; ho = '0; hl = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      out_ready = ($urandom_range(99) < ready_pct);
      #1;
      if (held && (!out_valid || out_bits !== hb || out_ones !== ho || out_last !== hl))
        stable_err++;
      held = 1'b0;
      if (out_valid) begin
        if (out_ready) begin
          q_bits.push_back(out_bits);
          q_ones.push_back(out_ones);
          q_last.push_back(out_last);
          q_rdy.push_back(in_ready);
          if (out_last) begin
            ok = 1'b1;
            break;
          end
        end else begin
          held = 1'b1; hb = out_bits; ho = out_ones; hl = out_last;
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_count = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_bits !== 15'h0 || out_ones !== 4'd0 || out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b bits=%h ones=%0d last=%b, want 0/0000/0/0",
               out_valid, out_bits, out_ones, out_last);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_zero();
    bit ok; int se;
    out_ready = 1'b1;
    accept(8'd0, ok);
    n_checks++;
    if (!ok || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL zero_latency: accepted=%b out_valid=%b one cycle after, want 1/1", ok, out_valid);
    end
    collect(100, ok, se);
    n_checks++;
    if (!ok || q_bits.size() != 1 || q_bits[0] !== 15'h0 || q_ones[0] !== 4'd0 || q_last[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_beat: done=%b beats=%0d first bits=%h ones=%0d last=%b, want 1 beat 0000/0/1",
               ok, q_bits.size(), (q_bits.size() > 0) ? q_bits[0] : 15'h7ABC,
               (q_ones.size() > 0) ? q_ones[0] : 4'hF, (q_last.size() > 0) ? q_last[0] : 1'bx);
    end
  endtask

  task automatic test_single_beat();
    bit ok; int se;
    logic [7:0]  cnts[2];
    logic [14:0] exp_bits[2];
    cnts[0] = 8'd7;  exp_bits[0] = 15'h007F;
    cnts[1] = 8'd15; exp_bits[1] = 15'h7FFF;
    for (int k = 0; k < 2; k++) begin
      accept(cnts[k], ok);
      collect(100, ok, se);
      n_checks++;
      if (!ok || q_bits.size() != 1 || q_bits[0] !== exp_bits[k] ||
          q_ones[0] !== cnts[k][3:0] || q_last[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL single_%0d: done=%b beats=%0d bits=%h ones=%0d, want 1 beat %h/%0d last",
                 cnts[k], ok, q_bits.size(), (q_bits.size() > 0) ? q_bits[0] : 15'h0,
                 (q_ones.size() > 0) ? q_ones[0] : 4'h0, exp_bits[k], cnts[k]);
      end
    end
  endtask

  task automatic test_two_beats();
    bit ok; int se;
    accept(8'd16, ok);
    collect(100, ok, se);
    n_checks++;
    if (!ok || q_bits.size() != 2) begin
      n_fail++; $display("FAIL c16_beats: done=%b beats=%0d want 2", ok, q_bits.size());
    end else begin
      n_checks++;
      if (q_bits[0] !== 15'h7FFF || q_ones[0] !== 4'd15 || q_last[0] !== 1'b0) begin
        n_fail++; $display("FAIL c16_beat1: got %h/%0d/%b want 7fff/15/0", q_bits[0], q_ones[0], q_last[0]);
      end
      n_checks++;
      if (q_bits[1] !== 15'h0001 || q_ones[1] !== 4'd1 || q_last[1] !== 1'b1) begin
        n_fail++; $display("FAIL c16_beat2: got %h/%0d/%b want 0001/1/1", q_bits[1], q_ones[1], q_last[1]);
      end
      n_checks++;
      if (q_rdy[0] !== 1'b0 || q_rdy[1] !== 1'b1) begin
        n_fail++; $display("FAIL c16_in_ready: got beat1=%b beat2=%b want 0/1", q_rdy[0], q_rdy[1]);
      end
    end
  endtask

  task automatic test_stall_255();
    bit ok; int se; int sum; int bad;
    accept(8'd255, ok);
    collect(50, ok, se);
    sum = 0; bad = 0;
    foreach (q_bits[i]) begin
      sum += int'(q_ones[i]);
      if (q_bits[i] !== 15'h7FFF || q_ones[i] !== 4'd15) bad++;
      if ($countones(q_bits[i]) != int'(q_ones[i])) bad++;
    end
    n_checks++;
    if (!ok || q_bits.size() != 17) begin
      n_fail++; $display("FAIL c255_beats: done=%b beats=%0d want 17 (last only on 17th)", ok, q_bits.size());
    end
    n_checks++;
    if (bad != 0 || sum != 255) begin
      n_fail++; $display("FAIL c255_content: bad beats=%0d ones sum=%0d want 0/255", bad, sum);
    end
    n_checks++;
    if (se != 0) begin
      n_fail++; $display("FAIL c255_stable: %0d stalled cycles changed outputs, want 0", se);
    end
  endtask

  task automatic test_back_to_back();
    logic [14:0] eb[3];
    logic [3:0]  eo[3];
    logic        el[3];
    int bad; bit accepted;
    eb[0] = 15'h0007; eo[0] = 4'd3;  el[0] = 1'b1;
    eb[1] = 15'h7FFF; eo[1] = 4'd15; el[1] = 1'b0;
    eb[2] = 15'h7FFF; eo[2] = 4'd15; el[2] = 1'b1;
    bad = 0; accepted = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_count = 8'd3;
    #1;
    if (in_ready) accepted = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (k == 0) in_count = 8'd30;
      if (k == 1) begin in_valid = 1'b0; in_count = 8'hA5; end
      #1;
      if (k == 0 && !in_ready) bad++;
      if (out_valid !== 1'b1 || out_bits !== eb[k] || out_ones !== eo[k] || out_last !== el[k]) bad++;
      if ($countones(out_bits) != int'(out_ones)) bad++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (!accepted || bad != 0) begin
      n_fail++; $display("FAIL back_to_back: first accept=%b mismatched beats=%0d want 1/0", accepted, bad);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_idle: out_valid=%b after burst, want 0", out_valid);
    end
  endtask

  task automatic test_mid_burst_reset();
    bit ok; int se;
    out_ready = 1'b1;
    accept(8'd200, ok);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (!ok || out_valid !== 1'b1 || out_ones !== 4'd15 || out_last !== 1'b0) begin
      n_fail++; $display("FAIL c200_beat5: accepted=%b valid=%b ones=%0d last=%b want 1/1/15/0",
                         ok, out_valid, out_ones, out_last);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_bits !== 15'h0 || in_ready !== 1'b1) begin
      n_fail++; $display("FAIL mid_reset: valid=%b bits=%h in_ready=%b want 0/0000/1",
                         out_valid, out_bits, in_ready);
    end
    @(negedge clk);
    reset = 1'b1;
    accept(8'd1, ok);
    collect(100, ok, se);
    n_checks++;
    if (!ok || q_bits.size() != 1 || q_bits[0] !== 15'h0001 || q_ones[0] !== 4'd1 || q_last[0] !== 1'b1) begin
      n_fail++; $display("FAIL post_reset_c1: done=%b beats=%0d bits=%h want 1 beat 0001 last",
                         ok, q_bits.size(), (q_bits.size() > 0) ? q_bits[0] : 15'h0);
    end
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_count = '0; out_ready = 1'b1;
    test_reset();
    test_zero();
    test_single_beat();
    test_two_beats();
    test_stall_255();
    test_back_to_back();
    test_mid_burst_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
